// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says display and input-checking blocks.
// Both sides map a stored sequence code to a button/LED through the same
// function so that what the player sees matches what the checker expects.
package simon_pkg;

    localparam int SEQ_LEN = 32;
    localparam int CODE_W  = 3;
    localparam int LED_W   = 4;
    localparam int ROUND_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_DONE
    } player_state_t;

    // Codes 0..3 select one of the four buttons; anything larger is invalid
    // and lights nothing.
    function automatic logic [LED_W-1:0] code_to_led(input logic [CODE_W-1:0] code);
        logic [LED_W-1:0] led;
        led = '0;
        case (code)
            3'd0:    led = 4'b0001;
            3'd1:    led = 4'b0010;
            3'd2:    led = 4'b0100;
            3'd3:    led = 4'b1000;
            default: led = 4'b0000;
        endcase
        return led;
    endfunction

    function automatic logic is_bad_code(input logic [CODE_W-1:0] code);
        return code > 3'd3;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one lit or dark phase of the playback.
// Loading a length of N makes expire high in the N-th cycle after the load,
// i.e. the last cycle of the phase, so the owner can switch phase on the
// same edge the timer runs out.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] length,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= length - WIDTH'(1);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays the stored Simon Says sequence on the four button LEDs, steps 0
// through the latched round, each step lit for ON_CYCLES then dark for
// OFF_CYCLES, and pulses done once the final dark gap has elapsed.
module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 50_000_000,
    parameter int OFF_CYCLES = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ROUND_W-1:0] round,
    input  logic [CODE_W-1:0]  segment [SEQ_LEN],
    output logic [LED_W-1:0]   led,
    output logic               busy,
    output logic               done,
    output logic               bad_code
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PW         = $clog2(MAX_CYCLES + 1);
    localparam logic [PW-1:0] ON_LEN  = PW'(ON_CYCLES);
    localparam logic [PW-1:0] OFF_LEN = PW'(OFF_CYCLES);

    player_state_t      state, state_next;
    logic [ROUND_W-1:0] idx, idx_next;
    logic [ROUND_W-1:0] last, last_next;
    logic [ROUND_W-1:0] idx_inc;
    logic [LED_W-1:0]   led_q, led_next;
    logic               bad_q, bad_next;
    logic               timer_load;
    logic [PW-1:0]      timer_len;
    logic               expire;

    phase_timer #(
        .WIDTH (PW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .length (timer_len),
        .expire (expire)
    );

    assign idx_inc = idx + 5'd1;

    // State and datapath registers; led and bad_code are registered so they
    // change exactly on the edge that enters or leaves a lit phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            last  <= '0;
            led_q <= '0;
            bad_q <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            last  <= last_next;
            led_q <= led_next;
            bad_q <= bad_next;
        end
    end

    // Next-state logic: segment is sampled at the moment a step is entered,
    // and the end test is equality with the latched round so idx never wraps.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        last_next  = last;
        led_next   = led_q;
        bad_next   = bad_q;
        timer_load = 1'b0;
        timer_len  = ON_LEN;
        case (state)
            ST_IDLE: begin
                led_next = '0;
                if (start) begin
                    state_next = ST_ON;
                    last_next  = round;
                    idx_next   = '0;
                    led_next   = code_to_led(segment[0]);
                    bad_next   = is_bad_code(segment[0]);
                    timer_load = 1'b1;
                    timer_len  = ON_LEN;
                end
            end
            ST_ON: begin
                if (expire) begin
                    state_next = ST_OFF;
                    led_next   = '0;
                    timer_load = 1'b1;
                    timer_len  = OFF_LEN;
                end
            end
            ST_OFF: begin
                if (expire) begin
                    if (idx == last) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ON;
                        idx_next   = idx_inc;
                        led_next   = code_to_led(segment[idx_inc]);
                        bad_next   = bad_q | is_bad_code(segment[idx_inc]);
                        timer_load = 1'b1;
                        timer_len  = ON_LEN;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                led_next   = '0;
            end
        endcase
    end

    assign led      = led_q;
    assign busy     = (state == ST_ON) || (state == ST_OFF);
    assign done     = (state == ST_DONE);
    assign bad_code = bad_q;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player with short phases. Each accepted
// start pushes the full expected per-cycle output trace into a queue, and
// the drain loop pops one entry per clock and compares it with the DUT.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int ON  = 4;
    localparam int OFF = 2;

    typedef logic [CODE_W-1:0] seg_arr_t [SEQ_LEN];

    typedef struct packed {
        logic [LED_W-1:0] led;
        logic             busy;
        logic             done;
        logic             bad;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic [ROUND_W-1:0] round;
    seg_arr_t           segment;
    logic [LED_W-1:0]   led;
    logic               busy;
    logic               done;
    logic               bad_code;

    exp_t exp_q[$];
    logic model_bad;
    int   vectors;
    int   miscompares;

    sequence_player #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .round    (round),
        .segment  (segment),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .bad_code (bad_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [LED_W-1:0] modelLed(input logic [CODE_W-1:0] code);
        logic [LED_W-1:0] l;
        l = '0;
        if (code < 3'd4) l[code[1:0]] = 1'b1;
        return l;
    endfunction

    function automatic void pushIdle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{led: 4'b0, busy: 1'b0, done: 1'b0, bad: model_bad});
    endfunction

    // Expected trace from the cycle after start through the done pulse.
    function automatic void pushPlay(input int last, input seg_arr_t seg);
        model_bad = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (seg[k] > 3'd3) model_bad = 1'b1;
            for (int c = 0; c < ON; c++)
                exp_q.push_back('{led: modelLed(seg[k]), busy: 1'b1, done: 1'b0, bad: model_bad});
            for (int c = 0; c < OFF; c++)
                exp_q.push_back('{led: 4'b0, busy: 1'b1, done: 1'b0, bad: model_bad});
        end
        exp_q.push_back('{led: 4'b0, busy: 1'b0, done: 1'b1, bad: model_bad});
    endfunction

    // Drive a start pulse with the given round and sequence; returns #1
    // after the edge that accepted it, i.e. in cycle t+1.
    task automatic applyStimulus(input int r, input seg_arr_t seg);
        segment = seg;
        round   = ROUND_W'(r);
        start   = 1'b1;
        pushPlay(r, seg);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Pop and compare one entry per cycle. Optional disturbances: a start
    // pulse at entry start_at, a round change at round_at, reset at abort_at.
    task automatic drain(input string name, input int start_at, input int round_at, input int abort_at);
        exp_t e;
        int   i;
        i = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s[%0d].led", name, i), 32'(led), 32'(e.led));
            checkOutput($sformatf("%s[%0d].busy", name, i), 32'(busy), 32'(e.busy));
            checkOutput($sformatf("%s[%0d].done", name, i), 32'(done), 32'(e.done));
            checkOutput($sformatf("%s[%0d].bad", name, i), 32'(bad_code), 32'(e.bad));
            if (i == abort_at) begin
                reset     = 1'b1;
                model_bad = 1'b0;
                exp_q.delete();
            end
            start = (i == start_at);
            if (i == round_at) round = 5'd31;
            @(posedge clk);
            #1;
            reset = 1'b0;
            start = 1'b0;
            i++;
        end
    endtask

    initial begin
        seg_arr_t s;
        vectors     = 0;
        miscompares = 0;
        model_bad   = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        round       = '0;
        for (int i = 0; i < SEQ_LEN; i++) segment[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pushIdle(10);
        drain("idle", -1, -1, -1);

        // Three-step round; a start during the done cycle must be ignored.
        for (int i = 0; i < SEQ_LEN; i++) s[i] = '0;
        s[0] = 3'd2; s[1] = 3'd0; s[2] = 3'd3;
        applyStimulus(2, s);
        pushIdle(3);
        drain("r2", 18, -1, -1);

        // Full 32-step round cycling through all four LEDs.
        for (int i = 0; i < SEQ_LEN; i++) s[i] = CODE_W'(i % 4);
        applyStimulus(31, s);
        pushIdle(2);
        drain("r31", -1, -1, -1);

        // Re-start and round change mid-playback must not alter anything.
        for (int i = 0; i < SEQ_LEN; i++) s[i] = CODE_W'($urandom_range(0, 3));
        applyStimulus(3, s);
        pushIdle(2);
        drain("perturb", 8, 3, -1);

        // Invalid code on step 1 blanks the LEDs and sets the sticky flag.
        for (int i = 0; i < SEQ_LEN; i++) s[i] = '0;
        s[0] = 3'd1; s[1] = 3'd5;
        applyStimulus(1, s);
        pushIdle(3);
        drain("bad", -1, -1, -1);

        // A clean round clears the flag on its start.
        s[1] = 3'd3;
        applyStimulus(0, s);
        pushIdle(2);
        drain("clear", -1, -1, -1);

        // Reset during step 2 aborts without done; next start begins at step 0.
        for (int i = 0; i < SEQ_LEN; i++) s[i] = CODE_W'((i + 1) % 4);
        applyStimulus(3, s);
        drain("abort", -1, -1, 13);
        pushIdle(8);
        drain("post_reset", -1, -1, -1);
        applyStimulus(1, s);
        pushIdle(2);
        drain("replay", -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
